// File: rtl/ibex_rf_arb_pkg.sv
// Shared types for the register-file write arbiter: FSM states, grant sources and the write record.
package ibex_rf_arb_pkg;

  typedef enum logic {ARB_CLEAR, ARB_RUN} arb_state_e;

  typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_LSU, GNT_CLR} gnt_src_e;

  localparam int unsigned RfAddrW = 5;
  localparam int unsigned RfDataW = 32;

  typedef struct packed {
    logic [RfAddrW-1:0] addr;
    logic [RfDataW-1:0] data;
  } rf_wr_t;

  // Upper half of the file does not exist on RV32E
  function automatic logic rf_addr_illegal(input bit rv32e, input logic [RfAddrW-1:0] addr);
    return rv32e && addr[4];
  endfunction

endpackage

// File: rtl/ibex_rf_arb_skid.sv
// One-entry LSU write buffer with a saturating count of cycles spent losing arbitration.
module ibex_rf_arb_skid import ibex_rf_arb_pkg::*; #(
  parameter int unsigned MaxLsuWait = 3,
  parameter type         entry_t    = rf_wr_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   capture,
  input  entry_t cap_entry,
  input  logic   grant,
  input  logic   discard,
  output logic   buf_valid,
  output entry_t buf_entry,
  output logic   age_max
);

  localparam int unsigned AgeW = $clog2(MaxLsuWait + 1);

  logic            valid_q;
  entry_t          entry_q;
  logic [AgeW-1:0] age_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      entry_q <= '0;
      age_q   <= '0;
    end else if (capture) begin
      valid_q <= 1'b1;
      entry_q <= cap_entry;
      age_q   <= '0;
    end else if (grant || discard) begin
      valid_q <= 1'b0;
      age_q   <= '0;
    end else if (valid_q && !age_max) begin
      age_q   <= age_q + AgeW'(1);
    end
  end

  assign buf_valid = valid_q;
  assign buf_entry = entry_q;
  assign age_max   = valid_q && (age_q == AgeW'(MaxLsuWait));

endmodule

// File: rtl/ibex_rf_write_arbiter.sv
// Arbitrates the single RF write port between WB and buffered LSU responses.
// Optional post-reset clear sweep when RF_ARB_CLEAR_EN is defined.
module ibex_rf_write_arbiter import ibex_rf_arb_pkg::*; #(
  parameter bit                    RV32E       = 1'b0,
  parameter int unsigned           DataWidth   = 32,
  parameter int unsigned           MaxLsuWait  = 3,
  parameter logic [DataWidth-1:0]  WordZeroVal = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wb_valid_i,
  input  logic [4:0]           wb_addr_i,
  input  logic [DataWidth-1:0] wb_data_i,
  output logic                 wb_ready_o,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_addr_i,
  input  logic [DataWidth-1:0] lsu_data_i,
  output logic                 lsu_ready_o,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  output logic                 we_a_o,
  output logic                 init_done_o,
  output logic                 addr_err_o
);

  typedef struct packed {
    logic [4:0]           addr;
    logic [DataWidth-1:0] data;
  } wr_t;

  arb_state_e state_q;
  logic       in_clear;
  logic [4:0] clr_addr;

`ifdef RF_ARB_CLEAR_EN
  localparam logic [4:0] ClrLast = RV32E ? 5'd15 : 5'd31;

  arb_state_e state_d;
  logic [4:0] clr_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ARB_CLEAR;
      clr_cnt_q <= 5'd1;
    end else begin
      state_q <= state_d;
      if (state_q == ARB_CLEAR) clr_cnt_q <= clr_cnt_q + 5'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ARB_CLEAR && clr_cnt_q == ClrLast) state_d = ARB_RUN;
  end

  assign clr_addr = clr_cnt_q;
`else
  assign state_q  = ARB_RUN;
  assign clr_addr = 5'd0;
`endif

  assign in_clear = (state_q == ARB_CLEAR);

  logic     init_done_q;
  logic     buf_valid, age_max;
  wr_t      buf_entry;
  logic     wb_acc, gnt_lsu, capture, discard;
  gnt_src_e gnt_src;
  wr_t      wr_sel;
  logic     illegal, we_d, err_d;

  // A starved buffer entry takes the port and stalls WB for that cycle
  assign wb_ready_o  = init_done_q && !age_max;
  assign lsu_ready_o = init_done_q && !buf_valid;
  assign wb_acc      = wb_valid_i && wb_ready_o;
  assign gnt_lsu     = init_done_q && buf_valid && (age_max || !wb_valid_i);
  assign capture     = lsu_valid_i && lsu_ready_o;
  // WB is younger in program order, so a pending load to the same register is stale
  assign discard     = wb_acc && buf_valid && (buf_entry.addr == wb_addr_i);

  ibex_rf_arb_skid #(
    .MaxLsuWait (MaxLsuWait),
    .entry_t    (wr_t)
  ) u_skid (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .capture   (capture),
    .cap_entry ('{addr: lsu_addr_i, data: lsu_data_i}),
    .grant     (gnt_lsu),
    .discard   (discard),
    .buf_valid (buf_valid),
    .buf_entry (buf_entry),
    .age_max   (age_max)
  );

  always_comb begin
    gnt_src = GNT_NONE;
    wr_sel  = '0;
    if (in_clear) begin
      gnt_src     = GNT_CLR;
      wr_sel.addr = clr_addr;
      wr_sel.data = WordZeroVal;
    end else if (wb_acc) begin
      gnt_src     = GNT_WB;
      wr_sel.addr = wb_addr_i;
      wr_sel.data = wb_data_i;
    end else if (gnt_lsu) begin
      gnt_src     = GNT_LSU;
      wr_sel      = buf_entry;
    end
  end

  assign illegal = rf_addr_illegal(RV32E, wr_sel.addr);
  assign we_d    = (gnt_src != GNT_NONE) && (wr_sel.addr != 5'd0) && !illegal;
  assign err_d   = (gnt_src == GNT_WB || gnt_src == GNT_LSU) && illegal;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      waddr_a_o   <= '0;
      wdata_a_o   <= '0;
      we_a_o      <= 1'b0;
      addr_err_o  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      we_a_o      <= we_d;
      addr_err_o  <= err_d;
      init_done_q <= !in_clear;
      if (gnt_src != GNT_NONE) begin
        waddr_a_o <= wr_sel.addr;
        wdata_a_o <= wr_sel.data;
      end
    end
  end

  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Randomized bench for ibex_rf_write_arbiter: RV32I and RV32E instances share stimulus,
// checked against a transaction-level model of the arbitration rules.
module tb_ibex_rf_write_arbiter;

  localparam int MAXW = 3;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        wb_valid = 1'b0, lsu_valid = 1'b0;
  logic [4:0]  wb_addr = '0, lsu_addr = '0;
  logic [31:0] wb_data = '0, lsu_data = '0;

  logic        wb_ready, lsu_ready, we, init_done, err;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wb_ready_e, lsu_ready_e, we_e, init_done_e, err_e;
  logic [4:0]  waddr_e;
  logic [31:0] wdata_e;

  always #5 clk = ~clk;

  ibex_rf_write_arbiter #(.RV32E(1'b0), .DataWidth(32), .MaxLsuWait(MAXW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_ready_o(wb_ready),
    .lsu_valid_i(lsu_valid), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data), .lsu_ready_o(lsu_ready),
    .waddr_a_o(waddr), .wdata_a_o(wdata), .we_a_o(we), .init_done_o(init_done), .addr_err_o(err)
  );

  ibex_rf_write_arbiter #(.RV32E(1'b1), .DataWidth(32), .MaxLsuWait(MAXW)) dut_e (
    .clk_i(clk), .rst_ni(rst_ni),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_ready_o(wb_ready_e),
    .lsu_valid_i(lsu_valid), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data), .lsu_ready_o(lsu_ready_e),
    .waddr_a_o(waddr_e), .wdata_a_o(wdata_e), .we_a_o(we_e), .init_done_o(init_done_e), .addr_err_o(err_e)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: pending load response plus how many cycles it has lost to WB
  bit          m_buf = 0;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_lost = 0;
  bit          obs_wbr, obs_lsr;

  task automatic step(input bit wv, input logic [4:0] wa, input logic [31:0] wd,
                      input bit lv, input logic [4:0] la, input logic [31:0] ld);
    bit exp_wbr, exp_lsr, wr, x_we, x_we_e, x_err_e;
    logic [4:0] wr_a;
    logic [31:0] wr_d;
    @(negedge clk);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
    #1;
    exp_wbr = !(m_buf && m_lost >= MAXW);
    exp_lsr = !m_buf;
    obs_wbr = wb_ready; obs_lsr = lsu_ready;
    chk("wb_ready", wb_ready, exp_wbr);
    chk("wb_ready_e", wb_ready_e, exp_wbr);
    chk("lsu_ready", lsu_ready, exp_lsr);
    chk("lsu_ready_e", lsu_ready_e, exp_lsr);
    wr = 0; wr_a = '0; wr_d = '0;
    if (wv && exp_wbr) begin
      wr = 1; wr_a = wa; wr_d = wd;
      if (m_buf && m_addr == wa) begin m_buf = 0; m_lost = 0; end
      else if (m_buf) m_lost++;
    end else if (m_buf) begin
      wr = 1; wr_a = m_addr; wr_d = m_data; m_buf = 0; m_lost = 0;
    end
    if (lv && exp_lsr) begin m_buf = 1; m_addr = la; m_data = ld; m_lost = 0; end
    x_we    = wr && wr_a != 0;
    x_we_e  = wr && wr_a != 0 && wr_a < 16;
    x_err_e = wr && wr_a >= 16;
    @(posedge clk); #1;
    chk("we", we, x_we);
    chk("we_e", we_e, x_we_e);
    chk("err", err, 1'b0);
    chk("err_e", err_e, x_err_e);
    if (x_we) begin chk("waddr", waddr, wr_a); chk("wdata", wdata, wr_d); end
    if (x_we_e) begin chk("waddr_e", waddr_e, wr_a); chk("wdata_e", wdata_e, wr_d); end
  endtask

  task automatic idle();
    step(0, '0, '0, 0, '0, '0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_we", we, 0);       chk("rst_waddr", waddr, 0);  chk("rst_wdata", wdata, 0);
    chk("rst_init", init_done, 0); chk("rst_err", err, 0);
    chk("rst_wbr", wb_ready, 0);   chk("rst_lsr", lsu_ready, 0);
    chk("rst_we_e", we_e, 0);   chk("rst_init_e", init_done_e, 0);
  endtask

`ifdef RF_ARB_CLEAR_EN
  task automatic sweep_check(input int upto);
    for (int k = 1; k <= upto; k++) begin
      @(posedge clk); #1;
      chk("clr_we", we, k <= 31);
      if (k <= 31) begin chk("clr_addr", waddr, k); chk("clr_data", wdata, 0); end
      chk("clr_init", init_done, k >= 32);
      chk("clr_we_e", we_e, k <= 15);
      if (k <= 15) chk("clr_addr_e", waddr_e, k);
      chk("clr_init_e", init_done_e, k >= 16);
    end
  endtask
`endif

  initial begin
    bit ok;
    #12;
    chk_reset_outs();
    @(negedge clk); rst_ni = 1'b1;
`ifdef RF_ARB_CLEAR_EN
    sweep_check(12);
    @(negedge clk); rst_ni = 1'b0; #1;
    chk_reset_outs();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    sweep_check(32);
`else
    @(posedge clk); #1;
    chk("init_first_edge", init_done, 1);
    chk("init_first_edge_e", init_done_e, 1);
    chk("no_wr_after_rst", we, 0);
`endif
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (init_done && init_done_e) ok = 1;
      else @(posedge clk);
    end
    chk("init_timeout", ok, 1);

    // WB alone: write one cycle later, single-cycle enable
    step(1, 5'd5, 32'hA5A5_0001, 0, '0, '0);
    chk("t2_waddr", waddr, 5);
    chk("t2_wdata", wdata, 32'hA5A5_0001);
    idle();
    chk("t2_we_drop", we, 0);

    // Starved LSU entry wins on its fourth waiting cycle
    step(0, '0, '0, 1, 5'd7, 32'h0000_0777);
    for (int i = 1; i <= 4; i++) step(1, 5'(i), 32'(i * 3), 0, '0, '0);
    chk("t3_wb_stall", obs_wbr, 0);
    chk("t3_lsu_we", we, 1);
    chk("t3_lsu_addr", waddr, 7);
    chk("t3_lsu_data", wdata, 32'h0000_0777);

    // Same-address WB drops the buffered load
    step(0, '0, '0, 1, 5'd9, 32'h1111_1111);
    step(1, 5'd9, 32'h2222_2222, 0, '0, '0);
    chk("t4_wdata", wdata, 32'h2222_2222);
    idle();
    chk("t4_lsu_ready", obs_lsr, 1);
    chk("t4_no_lsu_wr", we, 0);

    // x0 and RV32E illegal destinations
    step(1, 5'd0, 32'hDEAD_BEEF, 0, '0, '0);
    chk("t5_x0_ready", obs_wbr, 1);
    chk("t5_x0_we", we, 0);
    step(1, 5'd20, 32'h0BAD_0020, 0, '0, '0);
    chk("t5_e_we", we_e, 0);
    chk("t5_e_err", err_e, 1);
    chk("t5_i_we", we, 1);
    idle();
    chk("t5_e_err_pulse", err_e, 0);

    for (int n = 0; n < 3000; n++) begin
      logic [4:0] a_w, a_l;
      a_w = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3) * 7);
      a_l = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3) * 7);
      step($urandom_range(0, 9) < 7, a_w, $urandom, $urandom_range(0, 9) < 4, a_l, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
